// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the MIPS memory-side responder.
package mips_mem_responder_pkg;

  // Responder FSM encodings.
  typedef enum logic [1:0] {
    RSP_IDLE = 2'b00,
    RSP_WAIT = 2'b01,
    RSP_RESP = 2'b10
  } rsp_state_e;

  // Width of the wait-state down-counter (holds 0..15).
  localparam int RSP_CNT_W = 4;

  // A request is rejected if it is not word aligned, points past the end
  // of the RAM, or asks for a read and a write at the same time.
  function automatic logic req_error(input logic [31:0] addr,
                                     input logic        rd,
                                     input logic        wr,
                                     input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'h0) || (rd && wr);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Unified instruction/data memory port between the multicycle core and memory.
interface mips_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemBusy;
  logic        AddrError;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemBusy, AddrError
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemBusy, AddrError
  );
endinterface

// File: rtl/mips_mem_responder_word_ram.sv
// Single-port 32-bit word RAM: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module mips_word_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  cclk,
  input  logic                  rstb,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Write port: storage array, no reset so contents survive rstb.
  always_ff @(posedge cclk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  // Read register: holds the last successfully read word.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb)     rdata_q <= 32'h0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: captures a request,
// waits WAIT_STATES cycles, performs the RAM access and pulses MemReady.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   RSP_IDLE | no request outstanding; capture on MemRead|MemWrite
//   RSP_WAIT | request captured, counting down wait states
//   RSP_RESP | access done; MemReady (and maybe AddrError) high
import mips_mem_responder_pkg::*;

module mips_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 cclk,
  input  logic                 rstb,
  mips_mem_responder_if.slave  bus
);

  localparam logic [RSP_CNT_W-1:0] WS = RSP_CNT_W'(WAIT_STATES);

  rsp_state_e            state_q, state_d;
  logic [RSP_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  aerr_q, aerr_d;

  logic                  req;
  logic                  req_err;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_wdata;

  assign req     = bus.MemRead | bus.MemWrite;
  assign req_err = req_error(bus.Addr, bus.MemRead, bus.MemWrite, ADDR_WIDTH);

  // State, captured request and registered status outputs.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      aerr_q  <= aerr_d;
    end
  end

  // Next state, capture and RAM access strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    err_d     = err_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    aerr_d    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;

    case (state_q)
      RSP_IDLE: begin
        if (req) begin
          idx_d   = bus.Addr[ADDR_WIDTH+1:2];
          wdata_d = bus.WriteData;
          wr_d    = bus.MemWrite;
          err_d   = req_err;
          cnt_d   = WS;
          if (WAIT_STATES > 0) begin
            state_d = RSP_WAIT;
            busy_d  = 1'b1;
          end else begin
            // Zero wait states: access straight from the live request.
            state_d   = RSP_RESP;
            ready_d   = 1'b1;
            aerr_d    = req_err;
            ram_idx   = bus.Addr[ADDR_WIDTH+1:2];
            ram_wdata = bus.WriteData;
            ram_we    = bus.MemWrite & ~req_err;
            ram_re    = bus.MemRead  & ~req_err;
          end
        end
      end

      RSP_WAIT: begin
        cnt_d = cnt_q - RSP_CNT_W'(1);
        if (cnt_q == RSP_CNT_W'(1)) begin
          state_d = RSP_RESP;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          aerr_d  = err_q;
          ram_we  = wr_q  & ~err_q;
          ram_re  = ~wr_q & ~err_q;
        end
      end

      RSP_RESP: begin
        state_d = RSP_IDLE;
      end

      default: begin
        state_d = RSP_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  mips_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .cclk    (cclk),
    .rstb    (rstb),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_idx),
    .wdata_i (ram_wdata),
    .rdata_o (bus.ReadData)
  );

  assign bus.MemReady  = ready_q;
  assign bus.MemBusy   = busy_q;
  assign bus.AddrError = aerr_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench: one responder with 2 wait states, one with 0.
module tb_mips_mem_responder;

  logic cclk;
  logic rstb;
  int   n_checks;
  int   n_errors;
  int   pulses_b;

  mips_mem_responder_if bus_a ();
  mips_mem_responder_if bus_b ();

  mips_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (
    .cclk (cclk),
    .rstb (rstb),
    .bus  (bus_a.slave)
  );

  mips_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
    .cclk (cclk),
    .rstb (rstb),
    .bus  (bus_b.slave)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  always @(negedge cclk) if (bus_b.MemReady) pulses_b++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!sel) begin
      bus_a.MemRead = rd; bus_a.MemWrite = wr; bus_a.Addr = addr; bus_a.WriteData = wdata;
    end else begin
      bus_b.MemRead = rd; bus_b.MemWrite = wr; bus_b.Addr = addr; bus_b.WriteData = wdata;
    end
  endtask

  // One request on DUT A (sel=0) or B (sel=1): capture edge, then wait for
  // MemReady and check latency, busy cycles, AddrError, ReadData and the
  // one-cycle pulse width.
  task automatic xfer(input string tag, input bit sel, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic exp_aerr, input logic [31:0] exp_rd);
    int          lat, busy;
    logic        got, rdy, bsy, aerr;
    logic [31:0] rdat;
    lat = 0; busy = 0; got = 1'b0; aerr = 1'b0; rdat = 32'h0;
    @(negedge cclk);
    drive(sel, rd, wr, addr, wdata);
    @(posedge cclk);
    #1 drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge cclk);
      rdy  = sel ? bus_b.MemReady  : bus_a.MemReady;
      bsy  = sel ? bus_b.MemBusy   : bus_a.MemBusy;
      aerr = sel ? bus_b.AddrError : bus_a.AddrError;
      rdat = sel ? bus_b.ReadData  : bus_a.ReadData;
      if (rdy) begin
        got = 1'b1;
        break;
      end
      lat++;
      if (bsy) busy++;
    end
    if (!got) lat = 99;
    check({tag, ".lat"},   32'(lat), 32'(exp_lat));
    check({tag, ".busy"},  32'(busy), 32'(sel ? 0 : exp_lat));
    check({tag, ".aerr"},  {31'h0, aerr}, {31'h0, exp_aerr});
    check({tag, ".rdata"}, rdat, exp_rd);
    @(negedge cclk);
    rdy  = sel ? bus_b.MemReady  : bus_a.MemReady;
    aerr = sel ? bus_b.AddrError : bus_a.AddrError;
    check({tag, ".pulse"}, {30'h0, rdy, aerr}, 32'h0);
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    pulses_b = 0;
    rstb = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge cclk);
    check("rst.rdata", bus_a.ReadData, 32'h0);
    check("rst.ready", {31'h0, bus_a.MemReady}, 32'h0);
    check("rst.busy",  {31'h0, bus_a.MemBusy}, 32'h0);
    check("rst.aerr",  {31'h0, bus_a.AddrError}, 32'h0);
    rstb = 1'b1;

    // Preload and basic read/write with two wait states.
    xfer("wr_c",    0, 0, 1, 32'h0000000C, 32'hDEADBEEF, 2, 0, 32'h0);
    xfer("rd_c",    0, 1, 0, 32'h0000000C, 32'h0,        2, 0, 32'hDEADBEEF);
    xfer("wr_10",   0, 0, 1, 32'h00000010, 32'h12345678, 2, 0, 32'hDEADBEEF);
    xfer("rd_10",   0, 1, 0, 32'h00000010, 32'h0,        2, 0, 32'h12345678);
    // Error cases keep full latency and leave ReadData/RAM untouched.
    xfer("rd_mis",  0, 1, 0, 32'h00000006, 32'h0,        2, 1, 32'h12345678);
    xfer("wr_0",    0, 0, 1, 32'h00000000, 32'h11110000, 2, 0, 32'h12345678);
    xfer("wr_oor",  0, 0, 1, 32'h00000400, 32'hBAD0BAD0, 2, 1, 32'h12345678);
    xfer("rd_0",    0, 1, 0, 32'h00000000, 32'h0,        2, 0, 32'h11110000);
    xfer("wr_last", 0, 0, 1, 32'h000003FC, 32'h77777777, 2, 0, 32'h11110000);
    xfer("rd_last", 0, 1, 0, 32'h000003FC, 32'h0,        2, 0, 32'h77777777);
    xfer("wr_20",   0, 0, 1, 32'h00000020, 32'h20202020, 2, 0, 32'h77777777);
    xfer("both_20", 0, 1, 1, 32'h00000020, 32'h00BADBAD, 2, 1, 32'h77777777);
    xfer("rd_20",   0, 1, 0, 32'h00000020, 32'h0,        2, 0, 32'h20202020);
    xfer("rd_oor",  0, 1, 0, 32'h80000000, 32'h0,        2, 1, 32'h20202020);
    xfer("wr_24",   0, 0, 1, 32'h00000024, 32'hAAAA5555, 2, 0, 32'h20202020);

    // Reset in the middle of WAIT aborts a write.
    @(negedge cclk);
    drive(1'b0, 1'b0, 1'b1, 32'h00000024, 32'hFFFFFFFF);
    @(posedge cclk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge cclk);
    check("abort.busy_before", {31'h0, bus_a.MemBusy}, 32'h1);
    rstb = 1'b0;
    #1;
    check("abort.rdata", bus_a.ReadData, 32'h0);
    check("abort.ready", {31'h0, bus_a.MemReady}, 32'h0);
    check("abort.busy",  {31'h0, bus_a.MemBusy}, 32'h0);
    check("abort.aerr",  {31'h0, bus_a.AddrError}, 32'h0);
    @(negedge cclk);
    rstb = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge cclk);
      if (bus_a.MemReady) seen = 1'b1;
    end
    check("abort.no_ready", {31'h0, seen}, 32'h0);
    xfer("rd_24", 0, 1, 0, 32'h00000024, 32'h0, 2, 0, 32'hAAAA5555);

    // Zero-wait-state responder: ready in the cycle after capture.
    pulses_b = 0;
    xfer("b_wr_8", 1, 0, 1, 32'h00000008, 32'hA5A5A5A5, 0, 0, 32'h0);
    xfer("b_wr_c", 1, 0, 1, 32'h0000000C, 32'h5A5A5A5A, 0, 0, 32'h0);
    xfer("b_rd_8", 1, 1, 0, 32'h00000008, 32'h0,        0, 0, 32'hA5A5A5A5);
    xfer("b_rd_c", 1, 1, 0, 32'h0000000C, 32'h0,        0, 0, 32'h5A5A5A5A);
    xfer("b_mis",  1, 1, 0, 32'h0000000D, 32'h0,        0, 1, 32'h5A5A5A5A);
    check("b.pulses", 32'(pulses_b), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
